hyper_dev_responder: RTL

//  Synthesizable HyperBus device-side responder: the memory end of the HyperBus link driven by the hyperbus controller.

---
 rtl/hyper_dev_responder_if.sv | 34 +++
 rtl/hyper_dev_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hyper_dev_responder_if.sv
// ----------------------------------------------------------------------------
// hyper_dev_responder_if
//   HyperBus pin bundle between a controller (master) and the device-side
//   responder (slave). Clock and reset are not part of the bundle.
//
//   hyper_cs_ni      chip select, active low          (master -> slave)
//   hyper_ck_i       CK, true leg only                (master -> slave)
//   hyper_dq_i[7:0]  DQ driven by the controller      (master -> slave)
//   hyper_rwds_i     RWDS from controller, byte mask  (master -> slave)
//   hyper_dq_o[7:0]  DQ driven by the device          (slave -> master)
//   hyper_dq_oe_o    DQ output enable                 (slave -> master)
//   hyper_rwds_o     RWDS from device                 (slave -> master)
//   hyper_rwds_oe_o  RWDS output enable               (slave -> master)
// ----------------------------------------------------------------------------
interface hyper_dev_responder_if;
    logic       hyper_cs_ni;
    logic       hyper_ck_i;
    logic [7:0] hyper_dq_i;
    logic       hyper_rwds_i;
    logic [7:0] hyper_dq_o;
    logic       hyper_dq_oe_o;
    logic       hyper_rwds_o;
    logic       hyper_rwds_oe_o;

    modport master (
        output hyper_cs_ni, hyper_ck_i, hyper_dq_i, hyper_rwds_i,
        input  hyper_dq_o, hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o
    );

    modport slave (
        input  hyper_cs_ni, hyper_ck_i, hyper_dq_i, hyper_rwds_i,
        output hyper_dq_o, hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o
    );
endinterface

// File: rtl/hyper_dev_responder.sv
// ----------------------------------------------------------------------------
// hyper_dev_responder
//   Device end of a HyperBus link. Oversamples CK/CS#/DQ/RWDS on sys_clk,
//   decodes the 48-bit command-address and serves linear read/write bursts
//   from an internal array of 16-bit words.
//
//   sys_clk  oversampling clock, at least 4x the HyperBus CK frequency
//   rst_n    asynchronous reset, active high
//   hyper    HyperBus pins (slave modport of hyper_dev_responder_if)
//   busy_o   high whenever a transaction is in progress
//   err_o    sticky: CS# released before the command-address was complete
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for CS# to fall
// ST_CA   | shifting in the six command-address bytes, RWDS held low
// ST_LAT  | counting initial-latency CK edges, RWDS held low
// ST_DATA | read: driving DQ/RWDS; write: capturing bytes into the array
// ----------------------------------------------------------------------------
module hyper_dev_responder #(
    parameter int          MemWords = 1024,
    parameter int          Latency  = 6,
    parameter logic [15:0] CfgReg0  = 16'h8F1F
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    hyper_dev_responder_if.slave hyper,
    output logic                 busy_o,
    output logic                 err_o
);
    localparam int         AddrW   = $clog2(MemWords);
    localparam logic [7:0] LatInit = 8'(2 * Latency - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CA, ST_LAT, ST_DATA} state_t;
    state_t state;

    // Same synchronizer depth on every input keeps DQ/RWDS aligned to CK.
    logic [1:0] cs_sync, ck_sync, rwds_sync;
    logic [7:0] dq_meta, dq_s;
    logic       cs_prev, ck_prev;
    logic       cs_s, ck_s, rwds_s;
    logic       ck_edge, cs_rise, cs_fall;

    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            cs_sync   <= 2'b11;
            ck_sync   <= 2'b00;
            rwds_sync <= 2'b00;
            dq_meta   <= 8'h00;
            dq_s      <= 8'h00;
            cs_prev   <= 1'b1;
            ck_prev   <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], hyper.hyper_cs_ni};
            ck_sync   <= {ck_sync[0], hyper.hyper_ck_i};
            rwds_sync <= {rwds_sync[0], hyper.hyper_rwds_i};
            dq_meta   <= hyper.hyper_dq_i;
            dq_s      <= dq_meta;
            cs_prev   <= cs_sync[1];
            ck_prev   <= ck_sync[1];
        end
    end

    assign cs_s    = cs_sync[1];
    assign ck_s    = ck_sync[1];
    assign rwds_s  = rwds_sync[1];
    // Gating with CS# also makes CS# rise win over a coincident CK edge.
    assign ck_edge = (ck_s != ck_prev) && !cs_s;
    assign cs_rise = cs_s && !cs_prev;
    assign cs_fall = !cs_s && cs_prev;

    logic [2:0]       byte_cnt;
    logic [7:0]       lat_cnt;
    logic [AddrW-1:0] addr;
    logic             is_read, is_reg;
    logic [7:0]       hi_byte;
    logic             hi_mask;
    logic [7:0]       dq_o_q;
    logic             dq_oe_q, rwds_o_q, rwds_oe_q;

    logic [15:0] mem [MemWords];
    logic [15:0] rd_word;
    logic        we_hi, we_lo;

    assign rd_word = is_reg ? CfgReg0 : mem[addr];

    // A word is committed on its fall byte; a lone rise byte never lands.
    always_comb begin
        we_hi = 1'b0;
        we_lo = 1'b0;
        if (state == ST_DATA && ck_edge && !ck_s && !is_read && !is_reg) begin
            we_hi = !hi_mask;
            we_lo = !rwds_s;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (we_hi) mem[addr][15:8] <= hi_byte;
        if (we_lo) mem[addr][7:0]  <= dq_s;
    end

    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= ST_IDLE;
            byte_cnt  <= 3'd0;
            lat_cnt   <= 8'd0;
            addr      <= '0;
            is_read   <= 1'b0;
            is_reg    <= 1'b0;
            hi_byte   <= 8'h00;
            hi_mask   <= 1'b1;
            dq_o_q    <= 8'h00;
            dq_oe_q   <= 1'b0;
            rwds_o_q  <= 1'b0;
            rwds_oe_q <= 1'b0;
            busy_o    <= 1'b0;
            err_o     <= 1'b0;
        end else if (cs_rise) begin
            state     <= ST_IDLE;
            dq_o_q    <= 8'h00;
            dq_oe_q   <= 1'b0;
            rwds_o_q  <= 1'b0;
            rwds_oe_q <= 1'b0;
            busy_o    <= 1'b0;
            if (state == ST_CA) err_o <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state     <= ST_CA;
                        byte_cnt  <= 3'd0;
                        hi_mask   <= 1'b1;
                        rwds_o_q  <= 1'b0;
                        rwds_oe_q <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end
                ST_CA: begin
                    if (ck_edge) begin
                        byte_cnt <= byte_cnt + 3'd1;
                        // The address accumulates CA[44:16] then CA[2:0];
                        // truncation to AddrW gives the modulo-depth wrap.
                        case (byte_cnt)
                            3'd0: begin
                                is_read <= dq_s[7];
                                is_reg  <= dq_s[6];
                                addr    <= AddrW'({3'b000, dq_s[4:0]});
                            end
                            3'd1, 3'd2, 3'd3: addr <= AddrW'({addr, dq_s});
                            3'd5: begin
                                addr <= AddrW'({addr, dq_s[2:0]});
                                if (!is_read && is_reg) begin
                                    state     <= ST_DATA;
                                    rwds_oe_q <= 1'b0;
                                end else begin
                                    state   <= ST_LAT;
                                    lat_cnt <= LatInit;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LAT: begin
                    if (ck_edge) begin
                        if (lat_cnt == 8'd0) begin
                            state <= ST_DATA;
                            if (is_read) dq_oe_q   <= 1'b1;
                            else         rwds_oe_q <= 1'b0;
                        end else begin
                            lat_cnt <= lat_cnt - 8'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (ck_edge) begin
                        if (is_read) begin
                            if (ck_s) begin
                                dq_o_q   <= rd_word[15:8];
                                rwds_o_q <= 1'b1;
                            end else begin
                                dq_o_q   <= rd_word[7:0];
                                rwds_o_q <= 1'b0;
                                addr     <= addr + AddrW'(1);
                            end
                        end else if (ck_s) begin
                            hi_byte <= dq_s;
                            hi_mask <= rwds_s;
                        end else begin
                            hi_mask <= 1'b1;
                            addr    <= addr + AddrW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign hyper.hyper_dq_o      = dq_o_q;
    assign hyper.hyper_dq_oe_o   = dq_oe_q;
    assign hyper.hyper_rwds_o    = rwds_o_q;
    assign hyper.hyper_rwds_oe_o = rwds_oe_q;
endmodule
